caliptra_fpga_sync_apb_seq: RTL and testbench
=============================================

# caliptra_fpga_sync_apb_seq

APB master sequencer that turns single host-side register requests into correctly phased APB transfers into `caliptra_top`. It sits between the FPGA sync register block and the Caliptra APB slave port. It replaces direct software toggling of `psel` and `penable` with a hardware SETUP/ACCESS state machine. It adds a wait-state timeout and transfer/timeout statistics.

## Interface
- `ADDR_W`, 32: APB address width.
- `USER_W`, 32: PAUSER width.
- `TIMEOUT_CYCLES`, 256: maximum ACCESS cycles before abort; 0 disables the timeout.
- `aclk` input 1: clock; all logic on posedge.
- `rstn` input 1: asynchronous, active-low reset.
- `req_valid` input 1: request offered.
- `req_ready` output 1: request accepted when high with `req_valid`.
- `req_write` input 1: 1 = write, 0 = read.
- `req_addr` input ADDR_W: transfer address.
- `req_wdata` input 32: write data.
- `req_pprot` input 3: PPROT value.
- `req_pauser` input USER_W: PAUSER value.
- `rsp_valid` output 1: response available.
- `rsp_ready` input 1: response consumed.
- `rsp_rdata` output 32: read data; 0 for writes and for timeouts.
- `rsp_slverr` output 1: PSLVERR sampled, or timeout.
- `rsp_timeout` output 1: transfer aborted by the timeout.
- `psel`, `penable`, `pwrite` output 1 each: APB master controls.
- `paddr` output ADDR_W: APB address.
- `pwdata` output 32: APB write data.
- `pprot` output 3: APB protection.
- `pauser` output USER_W: APB user field.
- `prdata` input 32: APB read data.
- `pready` input 1: APB ready.
- `pslverr` input 1: APB slave error.
- `busy` output 1: state is not IDLE.
- `txn_count` output 32: number of completed responses; wraps.
- `timeout_count` output 16: number of timeouts; saturates at 0xFFFF.

## Operation
- States are IDLE, SETUP, ACCESS and RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, register all `req_*` fields onto the APB outputs and go to SETUP.
- SETUP:
  - `psel`=1, `penable`=0.
  - Clear the wait counter.
  - Always go to ACCESS next cycle.
- ACCESS:
  - `psel`=1, `penable`=1.
  - If `pready`=1: capture `prdata` (reads only, else 0) and `pslverr`, set `rsp_timeout`=0, go to RESP.
  - Else if `TIMEOUT_CYCLES`≠0 and the wait counter equals `TIMEOUT_CYCLES`-1: set `rsp_rdata`=0, `rsp_slverr`=1, `rsp_timeout`=1, go to RESP.
  - Otherwise increment the wait counter.
  - `pready` on the final allowed cycle is a normal completion, not a timeout.
- RESP:
  - `psel`=0, `penable`=0, `rsp_valid`=1.
  - Response fields hold stable until `rsp_ready`.
  - On `rsp_ready`: go to IDLE, increment `txn_count`, and increment `timeout_count` if `rsp_timeout`.
- `paddr`, `pwdata`, `pwrite`, `pprot` and `pauser` hold their last values while `psel`=0. They change only on request accept.
- `req_ready` is 0 in every state except IDLE. No request queueing.
- Requests offered while busy are not lost; they wait on `req_valid` under the normal handshake.

## Timing
- Reset values:
  - State IDLE, `req_ready`=1.
  - `psel`, `penable`, `pwrite`, `rsp_valid`, `rsp_slverr`, `rsp_timeout`, `busy` = 0.
  - `paddr`, `pwdata`, `pprot`, `pauser`, `rsp_rdata`, `txn_count`, `timeout_count` = 0.
- Accept at edge N:
  - SETUP during cycle N+1.
  - First ACCESS cycle N+2.
- Zero-wait slave (`pready`=1 at N+2): `rsp_valid` high from N+3.
- With `rsp_ready` held high, back-to-back throughput is one transfer every 4 cycles: accept, SETUP, ACCESS, RESP.
- Each wait state adds exactly one cycle.
- Timeout with `TIMEOUT_CYCLES`=T and `pready` never asserted:
  - ACCESS occupies cycles N+2..N+T+1.
  - `rsp_valid` rises at N+T+2.
  - `psel` falls the same cycle `rsp_valid` rises.
- `rsp_valid` never coincides with `psel`=1.
- `penable` is never 1 without `psel`=1.
- `penable` is never 1 in the cycle after IDLE.
- Asynchronous reset mid-transfer immediately forces `psel`/`penable`/`rsp_valid` to 0 and returns to IDLE. The in-flight request is dropped with no response and counters are cleared.
- `busy` is 1 in SETUP, ACCESS and RESP.
- Counters update on the RESP handshake edge only.

## Test plan
- Read of 0x3000_0040, `pready`=1 immediately, `prdata`=0xDEADBEEF:
  - `psel` at N+1, `penable` at N+2.
  - `rsp_valid` at N+3 with `rsp_rdata`=0xDEADBEEF, `rsp_slverr`=0.
  - `txn_count`=1.
- Write of 0x1234_5678 with 3 wait states and `pslverr`=1 on completion:
  - `pwdata` stable N..N+5, `rsp_valid` at N+6.
  - `rsp_slverr`=1, `rsp_timeout`=0, `rsp_rdata`=0.
- `TIMEOUT_CYCLES`=4, `pready` tied 0:
  - `psel` drops and `rsp_valid` rises at N+6 with `rsp_timeout`=1, `rsp_slverr`=1.
  - `timeout_count`=1.
  - Repeat with `pready`=1 at N+5: normal completion, `timeout_count` unchanged.
- Back-pressure: `rsp_ready`=0 for 10 cycles with a second `req_valid` pending:
  - Response fields stable and `req_ready`=0 throughout.
  - Second request accepted the cycle after the `rsp_ready` handshake.
- `rstn` pulsed low during ACCESS:
  - `psel`/`penable` drop asynchronously and no `rsp_valid` appears.
  - After release, a fresh read completes normally with `txn_count`=1.
- Force `timeout_count` to 0xFFFF, then trigger one more timeout: `timeout_count` stays 0xFFFF and `txn_count` increments.

Source files
------------

// File: rtl/caliptra_fpga_sync_apb_seq.sv
// APB master sequencer: turns single host register requests into phased
// SETUP/ACCESS transfers toward caliptra_top, with a wait-state timeout and
// transfer/timeout statistics.
module caliptra_fpga_sync_apb_seq #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned USER_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic              aclk,
  input  logic              rstn,
  // host request
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [2:0]        req_pprot,
  input  logic [USER_W-1:0] req_pauser,
  // host response
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_slverr,
  output logic              rsp_timeout,
  // APB master
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [31:0]       pwdata,
  output logic [2:0]        pprot,
  output logic [USER_W-1:0] pauser,
  input  logic [31:0]       prdata,
  input  logic              pready,
  input  logic              pslverr,
  // status
  output logic              busy,
  output logic [31:0]       txn_count,
  output logic [15:0]       timeout_count
);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

  localparam bit          TimeoutEn   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TimeoutLast = 32'(TIMEOUT_CYCLES) - 32'd1;

  state_e              state_q, state_d;
  logic [31:0]         wait_q;
  logic                pwrite_q;
  logic [ADDR_W-1:0]   paddr_q;
  logic [31:0]         pwdata_q;
  logic [2:0]          pprot_q;
  logic [USER_W-1:0]   pauser_q;
  logic [31:0]         rsp_rdata_q;
  logic                rsp_slverr_q;
  logic                rsp_timeout_q;
  logic [31:0]         txn_count_q;
  logic [15:0]         timeout_count_q;

  logic accept, access_done, access_to, rsp_hs;

  assign accept      = (state_q == StIdle) && req_valid;
  assign access_done = (state_q == StAccess) && pready;
  // pready on the last allowed cycle wins over the timeout
  assign access_to   = (state_q == StAccess) && !pready && TimeoutEn && (wait_q == TimeoutLast);
  assign rsp_hs      = (state_q == StResp) && rsp_ready;

  // State register
  always_ff @(posedge aclk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept) state_d = StSetup;
      StSetup:  state_d = StAccess;
      StAccess: if (access_done || access_to) state_d = StResp;
      StResp:   if (rsp_hs) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Handshake and APB phase outputs decoded from state
  always_comb begin
    req_ready = (state_q == StIdle);
    psel      = (state_q == StSetup) || (state_q == StAccess);
    penable   = (state_q == StAccess);
    rsp_valid = (state_q == StResp);
    busy      = (state_q != StIdle);
  end

  // APB address/data fields: loaded only on request accept, held otherwise
  always_ff @(posedge aclk or negedge rstn) begin
    if (!rstn) begin
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pprot_q  <= '0;
      pauser_q <= '0;
    end else if (accept) begin
      pwrite_q <= req_write;
      paddr_q  <= req_addr;
      pwdata_q <= req_wdata;
      pprot_q  <= req_pprot;
      pauser_q <= req_pauser;
    end
  end

  // Wait-state counter: cleared in SETUP, counts unready ACCESS cycles
  always_ff @(posedge aclk or negedge rstn) begin
    if (!rstn) begin
      wait_q <= '0;
    end else if (state_q == StSetup) begin
      wait_q <= '0;
    end else if ((state_q == StAccess) && !access_done && !access_to) begin
      wait_q <= wait_q + 32'd1;
    end
  end

  // Response capture at the end of ACCESS; held through RESP
  always_ff @(posedge aclk or negedge rstn) begin
    if (!rstn) begin
      rsp_rdata_q   <= '0;
      rsp_slverr_q  <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else if (access_done) begin
      rsp_rdata_q   <= pwrite_q ? 32'd0 : prdata;
      rsp_slverr_q  <= pslverr;
      rsp_timeout_q <= 1'b0;
    end else if (access_to) begin
      rsp_rdata_q   <= '0;
      rsp_slverr_q  <= 1'b1;
      rsp_timeout_q <= 1'b1;
    end
  end

  // Statistics: advance only on the response handshake edge
  always_ff @(posedge aclk or negedge rstn) begin
    if (!rstn) begin
      txn_count_q     <= '0;
      timeout_count_q <= '0;
    end else if (rsp_hs) begin
      txn_count_q <= txn_count_q + 32'd1;
      if (rsp_timeout_q && (timeout_count_q != 16'hFFFF)) begin
        timeout_count_q <= timeout_count_q + 16'd1;
      end
    end
  end

  assign pwrite        = pwrite_q;
  assign paddr         = paddr_q;
  assign pwdata        = pwdata_q;
  assign pprot         = pprot_q;
  assign pauser        = pauser_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_slverr    = rsp_slverr_q;
  assign rsp_timeout   = rsp_timeout_q;
  assign txn_count     = txn_count_q;
  assign timeout_count = timeout_count_q;

endmodule

// File: tb/tb_caliptra_fpga_sync_apb_seq.sv
// Scoreboard bench for caliptra_fpga_sync_apb_seq with a small APB slave model.
module tb_caliptra_fpga_sync_apb_seq;

  localparam int unsigned T = 4;

  logic        aclk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [2:0]  req_pprot = '0;
  logic [31:0] req_pauser = '0;
  logic        rsp_valid, rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_slverr, rsp_timeout;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [2:0]  pprot;
  logic [31:0] pauser;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic        busy;
  logic [31:0] txn_count;
  logic [15:0] timeout_count;

  caliptra_fpga_sync_apb_seq #(
    .ADDR_W(32), .USER_W(32), .TIMEOUT_CYCLES(T)
  ) dut (
    .aclk(aclk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_pprot(req_pprot),
    .req_pauser(req_pauser),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pprot(pprot), .pauser(pauser),
    .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .busy(busy), .txn_count(txn_count), .timeout_count(timeout_count)
  );

  always #5 aclk = ~aclk;

  // Slave model: pready after slv_wait unready ACCESS cycles, or never
  int          slv_wait  = 0;
  bit          slv_never = 1'b0;
  logic [31:0] slv_data  = '0;
  logic        slv_err   = 1'b0;
  int          acc_cnt;

  always @(posedge aclk or negedge rstn) begin
    if (!rstn) acc_cnt <= 0;
    else if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end

  assign pready  = psel & penable & ~slv_never & (acc_cnt >= slv_wait);
  assign prdata  = slv_data;
  assign pslverr = slv_err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] rdata;
    logic        slverr;
    logic        timeout;
  } rsp_t;

  rsp_t        exp_q[$];
  int unsigned exp_txn = 0;
  logic [15:0] exp_tc  = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic expect_rsp(input logic [31:0] rdata, input logic slverr, input logic timeout);
    rsp_t r;
    r.rdata   = rdata;
    r.slverr  = slverr;
    r.timeout = timeout;
    exp_q.push_back(r);
    exp_txn++;
    if (timeout && exp_tc != 16'hFFFF) exp_tc++;
  endtask

  // Monitor: pops the scoreboard on each response handshake, checks APB invariants
  always @(negedge aclk) begin
    if (rstn) begin
      checks++;
      if ((rsp_valid && psel) || (penable && !psel)) begin
        errors++;
        $display("FAIL apb_invariant: psel=%0b penable=%0b rsp_valid=%0b", psel, penable,
                 rsp_valid);
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got rdata=0x%08h slverr=%0b timeout=%0b, expected none",
                   rsp_rdata, rsp_slverr, rsp_timeout);
        end else begin
          rsp_t e;
          e = exp_q.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_slverr", 32'(rsp_slverr), 32'(e.slverr));
          chk("rsp_timeout", 32'(rsp_timeout), 32'(e.timeout));
        end
      end
    end
  end

  // Drive a request from the drive point; returns at accept edge + 1
  task automatic send(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    int n;
    @(posedge aclk); #1;
    req_write  = wr;
    req_addr   = addr;
    req_wdata  = wdata;
    req_pprot  = 3'b010;
    req_pauser = 32'hFFFF_0001;
    req_valid  = 1'b1;
    n = 0;
    @(negedge aclk);
    while (!req_ready && n < 50) begin
      @(negedge aclk);
      n++;
    end
    chk("req_ready_before_accept", 32'(req_ready), 32'd1);
    @(posedge aclk); #1;
    req_valid = 1'b0;
  endtask

  // Per-cycle phase check after accept; response appears at cycle r
  task automatic track(input int r, input logic [31:0] addr, input logic [31:0] wdata);
    for (int k = 1; k <= r; k++) begin
      @(negedge aclk);
      chk($sformatf("paddr_k%0d", k), paddr, addr);
      chk($sformatf("pwdata_k%0d", k), pwdata, wdata);
      if (k < r) begin
        chk($sformatf("psel_k%0d", k), 32'(psel), 32'd1);
        chk($sformatf("penable_k%0d", k), 32'(penable), (k == 1) ? 32'd0 : 32'd1);
        chk($sformatf("rsp_valid_k%0d", k), 32'(rsp_valid), 32'd0);
        chk($sformatf("busy_k%0d", k), 32'(busy), 32'd1);
      end else begin
        chk($sformatf("rsp_valid_k%0d", k), 32'(rsp_valid), 32'd1);
        chk($sformatf("psel_k%0d", k), 32'(psel), 32'd0);
      end
    end
  endtask

  task automatic chk_counts(input string tag);
    @(negedge aclk);
    chk({tag, "_txn_count"}, txn_count, exp_txn);
    chk({tag, "_timeout_count"}, 32'(timeout_count), 32'(exp_tc));
    chk({tag, "_idle_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_psel", 32'(psel), 32'd0);
    chk("rst_penable", 32'(penable), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_paddr", paddr, 32'd0);
    chk("rst_pauser", pauser, 32'd0);
    chk("rst_txn_count", txn_count, 32'd0);
    chk("rst_timeout_count", 32'(timeout_count), 32'd0);
    @(posedge aclk); #1;
    rstn = 1'b1;

    // Zero-wait read
    slv_data = 32'hDEAD_BEEF;
    expect_rsp(32'hDEAD_BEEF, 1'b0, 1'b0);
    send(1'b0, 32'h3000_0040, 32'h0);
    track(3, 32'h3000_0040, 32'h0);
    chk("rd_pprot", 32'(pprot), 32'd2);
    chk("rd_pauser", pauser, 32'hFFFF_0001);
    chk("rd_pwrite", 32'(pwrite), 32'd0);
    chk_counts("rd");

    // Write, 3 wait states, slave error; pready on the final allowed cycle
    slv_wait = 3;
    slv_err  = 1'b1;
    slv_data = 32'h5555_AAAA;
    expect_rsp(32'h0, 1'b1, 1'b0);
    send(1'b1, 32'h3000_0044, 32'h1234_5678);
    track(6, 32'h3000_0044, 32'h1234_5678);
    chk_counts("wr");

    // Timeout: pready never asserted
    slv_err   = 1'b0;
    slv_never = 1'b1;
    expect_rsp(32'h0, 1'b1, 1'b1);
    send(1'b0, 32'h3000_0048, 32'h0);
    track(T + 2, 32'h3000_0048, 32'h0);
    chk_counts("to");

    // pready at the last ACCESS cycle: normal completion
    slv_never = 1'b0;
    slv_wait  = 3;
    slv_data  = 32'hA5A5_0001;
    expect_rsp(32'hA5A5_0001, 1'b0, 1'b0);
    send(1'b0, 32'h3000_004C, 32'h0);
    track(6, 32'h3000_004C, 32'h0);
    chk_counts("late");

    // Back-pressure with a second request pending
    slv_wait  = 0;
    slv_data  = 32'h1111_1111;
    rsp_ready = 1'b0;
    expect_rsp(32'h1111_1111, 1'b0, 1'b0);
    send(1'b0, 32'h0000_0010, 32'h0);
    req_write = 1'b1;
    req_addr  = 32'h0000_0020;
    req_wdata = 32'h2222_2222;
    req_valid = 1'b1;
    track(3, 32'h0000_0010, 32'h0);
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_rdata", rsp_rdata, 32'h1111_1111);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_paddr", paddr, 32'h0000_0010);
    end
    @(posedge aclk); #1;
    rsp_ready = 1'b1;
    expect_rsp(32'h0, 1'b0, 1'b0);
    @(negedge aclk);
    @(negedge aclk);
    chk("bp_ready_after_hs", 32'(req_ready), 32'd1);
    @(posedge aclk); #1;
    req_valid = 1'b0;
    track(3, 32'h0000_0020, 32'h2222_2222);
    chk_counts("bp");

    // Asynchronous reset during ACCESS drops the transfer
    slv_never = 1'b1;
    send(1'b0, 32'h0000_0050, 32'h0);
    @(negedge aclk);
    @(negedge aclk);
    chk("rst_mid_access", 32'({psel, penable}), 32'd3);
    #2 rstn = 1'b0;
    #1;
    chk("rst_mid_psel", 32'(psel), 32'd0);
    chk("rst_mid_penable", 32'(penable), 32'd0);
    chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_mid_txn_count", txn_count, 32'd0);
    exp_txn = 0;
    exp_tc  = '0;
    @(posedge aclk); #1;
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      chk("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    slv_never = 1'b0;
    slv_wait  = 0;
    slv_data  = 32'hCAFE_F00D;
    expect_rsp(32'hCAFE_F00D, 1'b0, 1'b0);
    send(1'b0, 32'h0000_0054, 32'h0);
    track(3, 32'h0000_0054, 32'h0);
    chk_counts("post_rst");

    // Saturating timeout counter
    @(posedge aclk); #1;
    force dut.timeout_count_q = 16'hFFFF;
    #1;
    release dut.timeout_count_q;
    exp_tc    = 16'hFFFF;
    slv_never = 1'b1;
    expect_rsp(32'h0, 1'b1, 1'b1);
    send(1'b0, 32'h0000_0058, 32'h0);
    track(T + 2, 32'h0000_0058, 32'h0);
    chk_counts("sat");

    repeat (3) @(negedge aclk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
